// File: rtl/id_reg_buf.sv
// Two-entry decode -> register-read skid buffer with exception drain control.
// Optional perf counters are enabled by defining ID_REG_BUF_PERF_EN.
module id_reg_buf #(
    parameter int PAYLOAD_W = 384
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_readygo,
    output logic                 id_allowin,
    input  logic [PAYLOAD_W-1:0] id_payload,
    input  logic                 id_excp_flag,
    input  logic [4:0]           id_rj0,
    input  logic [4:0]           id_rj1,
    input  logic [4:0]           id_rk0,
    input  logic [4:0]           id_rk1,
    input  logic [4:0]           id_rd0,
    input  logic [4:0]           id_rd1,
    input  logic                 reg_allowin,
    output logic                 reg_readygo,
    output logic [PAYLOAD_W-1:0] id_reg_payload,
    output logic                 id_reg_excp_flag,
    output logic [4:0]           id_reg_rj0,
    output logic [4:0]           id_reg_rj1,
    output logic [4:0]           id_reg_rk0,
    output logic [4:0]           id_reg_rk1,
    output logic [4:0]           id_reg_rd0,
`ifdef ID_REG_BUF_PERF_EN
    output logic [4:0]           id_reg_rd1,
    output logic [31:0]          perf_bubble_cnt,
    output logic [31:0]          perf_backpressure_cnt
`else
    output logic [4:0]           id_reg_rd1
`endif
);

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    // Side-band per entry: {excp, rj0, rj1, rk0, rk1, rd0, rd1}
    localparam int META_W = 31;

    state_t            state_q, state_d;
    logic              head_q, head_d;
    logic [1:0]        count_q, count_d;
    logic              push, pop, wr_idx;
    logic [META_W-1:0] wr_meta, rd_meta;
    logic [PAYLOAD_W-1:0] rd_payload;

    logic [PAYLOAD_W-1:0] payload_q [2];
    logic [META_W-1:0]    meta_q    [2];

    assign id_allowin  = (count_q != 2'd2) && (state_q == NORMAL) && !flush;
    assign reg_readygo = (count_q != 2'd0);
    assign push        = id_readygo && id_allowin;
    assign pop         = reg_readygo && reg_allowin;
    // Only one slot can be free when push and pop coincide, so head+count always lands on it.
    assign wr_idx      = head_q ^ count_q[0];
    assign wr_meta     = {id_excp_flag, id_rj0, id_rj1, id_rk0, id_rk1, id_rd0, id_rd1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push && !rst && (wr_idx == gi[0])) begin
                    payload_q[gi] <= id_payload;
                    meta_q[gi]    <= wr_meta;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        count_d = count_q;
        if (flush) begin
            state_d = NORMAL;
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
            if (push && id_excp_flag) begin
                state_d = DRAIN;
            end else if ((state_q == DRAIN) && pop && (count_q == 2'd1)) begin
                state_d = NORMAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Empty buffer presents all-zero fields so hazard logic only ever sees x0.
    assign rd_payload = reg_readygo ? payload_q[head_q] : '0;
    assign rd_meta    = reg_readygo ? meta_q[head_q]    : '0;

    assign id_reg_payload   = rd_payload;
    assign id_reg_excp_flag = rd_meta[30];
    assign id_reg_rj0       = rd_meta[29:25];
    assign id_reg_rj1       = rd_meta[24:20];
    assign id_reg_rk0       = rd_meta[19:15];
    assign id_reg_rk1       = rd_meta[14:10];
    assign id_reg_rd0       = rd_meta[9:5];
    assign id_reg_rd1       = rd_meta[4:0];

`ifdef ID_REG_BUF_PERF_EN
    logic [31:0] bubble_q, bubble_d;
    logic [31:0] bp_q, bp_d;

    assign bubble_d = bubble_q + {31'd0, (count_q == 2'd0)};
    assign bp_d     = bp_q + {31'd0, (reg_readygo && !reg_allowin)};

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= 32'd0;
            bp_q     <= 32'd0;
        end else begin
            bubble_q <= bubble_d;
            bp_q     <= bp_d;
        end
    end

    assign perf_bubble_cnt       = bubble_q;
    assign perf_backpressure_cnt = bp_q;
`endif

endmodule

// File: tb/tb_id_reg_buf.sv
// Randomized scoreboard bench for id_reg_buf: a queue-based model of the buffer
// predicts the head bundle, readiness and id_allowin every cycle.
`timescale 1ns/1ps
module tb_id_reg_buf;
    localparam int PW = 384;

    logic          clk = 1'b0;
    logic          rst, flush, id_readygo, id_excp_flag, reg_allowin;
    logic [PW-1:0] id_payload;
    logic [4:0]    id_rj0, id_rj1, id_rk0, id_rk1, id_rd0, id_rd1;
    logic          id_allowin, reg_readygo, id_reg_excp_flag;
    logic [PW-1:0] id_reg_payload;
    logic [4:0]    id_reg_rj0, id_reg_rj1, id_reg_rk0, id_reg_rk1, id_reg_rd0, id_reg_rd1;
`ifdef ID_REG_BUF_PERF_EN
    logic [31:0]   perf_bubble_cnt, perf_backpressure_cnt;
`endif

    always #5 clk = ~clk;

    id_reg_buf #(.PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_readygo(id_readygo), .id_allowin(id_allowin),
        .id_payload(id_payload), .id_excp_flag(id_excp_flag),
        .id_rj0(id_rj0), .id_rj1(id_rj1), .id_rk0(id_rk0),
        .id_rk1(id_rk1), .id_rd0(id_rd0), .id_rd1(id_rd1),
        .reg_allowin(reg_allowin), .reg_readygo(reg_readygo),
        .id_reg_payload(id_reg_payload), .id_reg_excp_flag(id_reg_excp_flag),
        .id_reg_rj0(id_reg_rj0), .id_reg_rj1(id_reg_rj1), .id_reg_rk0(id_reg_rk0),
        .id_reg_rk1(id_reg_rk1), .id_reg_rd0(id_reg_rd0),
`ifdef ID_REG_BUF_PERF_EN
        .id_reg_rd1(id_reg_rd1),
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_backpressure_cnt(perf_backpressure_cnt)
`else
        .id_reg_rd1(id_reg_rd1)
`endif
    );

    typedef struct packed {
        logic [PW-1:0] pay;
        logic [30:0]   meta;
    } ent_t;

    ent_t exp_q[$];
    bit   drain_m = 0;
    bit   mon_en  = 0;
    bit   chk_en  = 0;
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One bus cycle: drive, check id_allowin, then advance the model at the clock edge.
    task automatic step(input bit r, input bit rdy, input bit alw, input bit fl, input bit ex,
                        input logic [4:0] rj0);
        bit   exp_allow, push, pop;
        ent_t e;
        @(negedge clk);
        #1;
        rst = r; flush = fl; id_readygo = rdy; reg_allowin = alw; id_excp_flag = ex;
        id_payload = {12{$urandom}};
        id_rj0 = rj0;
        {id_rj1, id_rk0, id_rk1, id_rd0, id_rd1} = 25'($urandom);
        #1;
        exp_allow = (exp_q.size() < 2) && !drain_m && !fl;
        if (chk_en) check("id_allowin", PW'(id_allowin), PW'(exp_allow));
        push = rdy && exp_allow && !r;
        pop  = (exp_q.size() != 0) && alw;
        e.pay  = id_payload;
        e.meta = {ex, id_rj0, id_rj1, id_rk0, id_rk1, id_rd0, id_rd1};
        @(posedge clk);
        txn++;
        if (r || fl) begin
            exp_q.delete();
            drain_m = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                exp_q.push_back(e);
                if (ex) drain_m = 1;
            end
            if (exp_q.size() == 0) drain_m = 0;
        end
        $display("txn %0d rst=%0b fl=%0b rdy=%0b alw=%0b ex=%0b push=%0b pop=%0b depth=%0d",
                 txn, r, fl, rdy, alw, ex, push, pop && !r && !fl, exp_q.size());
    endtask

    // Monitor: compares the presented head against the scoreboard front each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("reg_readygo", PW'(reg_readygo), PW'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("head_payload", id_reg_payload, exp_q[0].pay);
                    check("head_meta", PW'({id_reg_excp_flag, id_reg_rj0, id_reg_rj1, id_reg_rk0,
                          id_reg_rk1, id_reg_rd0, id_reg_rd1}), PW'(exp_q[0].meta));
                end else begin
                    check("empty_payload", id_reg_payload, '0);
                    check("empty_meta", PW'({id_reg_excp_flag, id_reg_rj0, id_reg_rj1, id_reg_rk0,
                          id_reg_rk1, id_reg_rd0, id_reg_rd1}), '0);
                end
            end
        end
    end

    initial begin
        rst = 1; flush = 0; id_readygo = 0; reg_allowin = 0; id_excp_flag = 0;
        id_payload = '0;
        {id_rj0, id_rj1, id_rk0, id_rk1, id_rd0, id_rd1} = '0;
        step(1, 0, 0, 0, 0, 5'd0);
        step(1, 1, 1, 0, 0, 5'd0);
        mon_en = 1; chk_en = 1;

        // Single bundle through with downstream ready.
        step(0, 1, 1, 0, 0, 5'd5);
        step(0, 0, 1, 0, 0, 5'd0);
        step(0, 0, 1, 0, 0, 5'd0);

        // Fill under backpressure, hold, then drain in order.
        step(0, 1, 0, 0, 0, 5'd1);
        step(0, 1, 0, 0, 0, 5'd2);
        step(0, 1, 0, 0, 0, 5'd3);
        step(0, 0, 0, 0, 0, 5'd0);
        step(0, 0, 1, 0, 0, 5'd0);
        step(0, 0, 1, 0, 0, 5'd0);
        step(0, 0, 1, 0, 0, 5'd0);

        // Simultaneous push/pop at depth 1 to wrap the write index.
        step(0, 1, 0, 0, 0, 5'd10);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 5'(11 + i));
        step(0, 0, 1, 0, 0, 5'd0);

        // Exception bundle blocks younger entries until it pops.
        step(0, 1, 0, 0, 1, 5'd20);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 5'd21);
        step(0, 1, 1, 0, 0, 5'd22);
        step(0, 1, 1, 0, 0, 5'd23);
        step(0, 0, 1, 0, 0, 5'd0);

        // Flush at full depth overrides push and pop.
        step(0, 1, 0, 0, 0, 5'd30);
        step(0, 1, 0, 0, 0, 5'd31);
        step(0, 1, 1, 1, 0, 5'd32);
        step(0, 0, 0, 0, 0, 5'd0);

        // Reset mid-operation.
        step(0, 1, 0, 0, 0, 5'd7);
        step(0, 1, 0, 0, 0, 5'd8);
        step(1, 1, 1, 0, 0, 5'd9);
        step(0, 0, 0, 0, 0, 5'd0);

`ifdef ID_REG_BUF_PERF_EN
        step(1, 0, 0, 0, 0, 5'd0);
        check("perf_bubble_rst", PW'(perf_bubble_cnt), '0);
        check("perf_bp_rst", PW'(perf_backpressure_cnt), '0);
        step(0, 0, 0, 0, 0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0);
        step(0, 1, 0, 0, 0, 5'd4);
        step(0, 0, 0, 0, 0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0);
        @(negedge clk);
        check("perf_bubble", PW'(perf_bubble_cnt), PW'(32'd3));
        check("perf_bp", PW'(perf_backpressure_cnt), PW'(32'd2));
        step(1, 0, 0, 0, 0, 5'd0);
        check("perf_bubble_clr", PW'(perf_bubble_cnt), '0);
        check("perf_bp_clr", PW'(perf_backpressure_cnt), '0);
`endif

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) == 0), ($urandom_range(9) < 7), ($urandom_range(9) < 6),
                 ($urandom_range(24) == 0), ($urandom_range(7) == 0), 5'($urandom));
        end
        step(0, 0, 1, 0, 0, 5'd0);
        step(0, 0, 1, 0, 0, 5'd0);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
